// File: rtl/uart_tx_ctrl_if.sv
// Parallel-word handshake and serial-line bundle between the parity stage,
// the frame controller and the line driver.
interface uart_tx_ctrl_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] P_DATA;
    logic                  Data_Valid;
    logic                  PAR_EN;
    logic                  PAR_Bit;
    logic                  TX_OUT;
    logic                  Busy;

    modport master (
        output P_DATA, Data_Valid, PAR_EN, PAR_Bit,
        input  TX_OUT, Busy
    );

    modport slave (
        input  P_DATA, Data_Valid, PAR_EN, PAR_Bit,
        output TX_OUT, Busy
    );
endinterface

// File: rtl/uart_tx_ctrl.sv
// UART transmit frame controller: start bit, LSB-first data, optional parity
// bit from the upstream parity stage, stop bit; one bit per CLK cycle.
module uart_tx_ctrl #(
    parameter int DATA_WIDTH = 8
) (
    input  logic           CLK,
    input  logic           RST,
    uart_tx_ctrl_if.slave  bus
);
    localparam int CNT_W = (DATA_WIDTH > 2) ? $clog2(DATA_WIDTH) : 1;
    localparam logic [CNT_W-1:0] LAST_BIT = CNT_W'(DATA_WIDTH - 1);

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_START  = 3'd1,
        ST_DATA   = 3'd2,
        ST_PARITY = 3'd3,
        ST_STOP   = 3'd4
    } state_t;

    state_t                state_r, next_state_s;
    logic [DATA_WIDTH-1:0] shift_r, shift_next_s;
    logic [CNT_W-1:0]      cnt_r, cnt_next_s;
    logic                  par_en_r, par_en_next_s;
    logic                  tx_out_r, tx_next_s;
    logic                  busy_r, busy_next_s;

    // State, datapath and line registers; outputs are computed one edge ahead
    always_ff @(posedge CLK or posedge RST) begin
        if (RST) begin
            state_r  <= ST_IDLE;
            shift_r  <= '0;
            cnt_r    <= '0;
            par_en_r <= 1'b0;
            tx_out_r <= 1'b1;
            busy_r   <= 1'b0;
        end else begin
            state_r  <= next_state_s;
            shift_r  <= shift_next_s;
            cnt_r    <= cnt_next_s;
            par_en_r <= par_en_next_s;
            tx_out_r <= tx_next_s;
            busy_r   <= busy_next_s;
        end
    end

    // Next-state and next line value; START already presents data bit 0
    always_comb begin
        next_state_s  = state_r;
        shift_next_s  = shift_r;
        cnt_next_s    = cnt_r;
        par_en_next_s = par_en_r;
        tx_next_s     = 1'b1;
        case (state_r)
            ST_IDLE: begin
                if (bus.Data_Valid) begin
                    next_state_s  = ST_START;
                    shift_next_s  = bus.P_DATA;
                    cnt_next_s    = '0;
                    par_en_next_s = bus.PAR_EN;
                    tx_next_s     = 1'b0;
                end else begin
                    next_state_s  = ST_IDLE;
                end
            end
            ST_START: begin
                next_state_s = ST_DATA;
                tx_next_s    = shift_r[0];
                shift_next_s = {1'b0, shift_r[DATA_WIDTH-1:1]};
            end
            ST_DATA: begin
                // The counter tops out at the last data bit, so it never wraps
                if (cnt_r == LAST_BIT) begin
                    if (par_en_r) begin
                        next_state_s = ST_PARITY;
                        tx_next_s    = bus.PAR_Bit;
                    end else begin
                        next_state_s = ST_STOP;
                        tx_next_s    = 1'b1;
                    end
                end else begin
                    next_state_s = ST_DATA;
                    tx_next_s    = shift_r[0];
                    shift_next_s = {1'b0, shift_r[DATA_WIDTH-1:1]};
                    cnt_next_s   = cnt_r + CNT_W'(1);
                end
            end
            ST_PARITY: begin
                next_state_s = ST_STOP;
                tx_next_s    = 1'b1;
            end
            ST_STOP: begin
                next_state_s = ST_IDLE;
                tx_next_s    = 1'b1;
            end
            default: begin
                next_state_s = ST_IDLE;
                tx_next_s    = 1'b1;
            end
        endcase
        busy_next_s = (next_state_s != ST_IDLE);
    end

    assign bus.TX_OUT = tx_out_r;
    assign bus.Busy   = busy_r;
endmodule

// File: tb/tb_uart_tx_ctrl.sv
// Scoreboard bench for uart_tx_ctrl: each accepted frame pushes its expected
// per-cycle {Busy, TX_OUT} samples; an empty queue means the line must idle.
module tb_uart_tx_ctrl;
    localparam int DW = 8;

    logic CLK;
    logic RST;
    logic clk_run;
    logic mon_en;

    int n_checks;
    int n_errors;

    logic [1:0] exp_q [$];

    uart_tx_ctrl_if #(.DATA_WIDTH(DW)) bus ();

    uart_tx_ctrl #(.DATA_WIDTH(DW)) dut (
        .CLK (CLK),
        .RST (RST),
        .bus (bus.slave)
    );

    initial begin
        CLK = 1'b0;
        wait (clk_run === 1'b1);
        forever #5 CLK = ~CLK;
    end

    task automatic check_eq(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    // Line monitor: compare every cycle against the scoreboard (idle when empty)
    always @(negedge CLK) begin
        logic [1:0] exp_s;
        if (mon_en) begin
            if (exp_q.size() > 0) exp_s = exp_q.pop_front();
            else                  exp_s = 2'b01;
            check_eq("line {Busy,TX_OUT}", {30'd0, bus.Busy, bus.TX_OUT}, {30'd0, exp_s});
        end
    end

    task automatic push_frame(input logic [DW-1:0] d, input logic pe, input logic pb);
        exp_q.push_back(2'b10);
        for (int i = 0; i < DW; i++) exp_q.push_back({1'b1, d[i]});
        if (pe) exp_q.push_back({1'b1, pb});
        exp_q.push_back(2'b11);
    endtask

    task automatic cycles(input int n);
        repeat (n) @(posedge CLK);
        #1;
    endtask

    // Drive a one-cycle accept; called and returning at posedge+1
    task automatic send(input logic [DW-1:0] d, input logic pe, input logic pb);
        bus.P_DATA     = d;
        bus.PAR_EN     = pe;
        bus.PAR_Bit    = pb;
        bus.Data_Valid = 1'b1;
        cycles(1);
        bus.Data_Valid = 1'b0;
        push_frame(d, pe, pb);
    endtask

    initial begin
        n_checks       = 0;
        n_errors       = 0;
        mon_en         = 1'b0;
        clk_run        = 1'b0;
        bus.P_DATA     = 8'h00;
        bus.Data_Valid = 1'b0;
        bus.PAR_EN     = 1'b0;
        bus.PAR_Bit    = 1'b0;
        RST            = 1'b1;

        // Reset without any clock edge
        #3;
        check_eq("reset TX_OUT", {31'd0, bus.TX_OUT}, 32'd1);
        check_eq("reset Busy",   {31'd0, bus.Busy},   32'd0);
        clk_run = 1'b1;
        cycles(2);
        RST    = 1'b0;
        mon_en = 1'b1;
        cycles(20);

        // Parity frame 0xA5 with PAR_Bit=0
        send(8'hA5, 1'b1, 1'b0);
        cycles(14);

        // Parity frame carrying a 1 parity bit
        send(8'h07, 1'b1, 1'b1);
        cycles(14);

        // No-parity frame; PAR_Bit toggling must not matter
        send(8'h3C, 1'b0, 1'b0);
        for (int i = 0; i < 12; i++) begin
            bus.PAR_Bit = ~bus.PAR_Bit;
            cycles(1);
        end

        // Requests while busy are dropped and P_DATA/PAR_EN changes ignored
        send(8'h55, 1'b1, 1'b0);
        cycles(3);
        bus.P_DATA     = 8'hFF;
        bus.PAR_EN     = 1'b0;
        bus.Data_Valid = 1'b1;
        cycles(1);
        bus.Data_Valid = 1'b0;
        bus.PAR_EN     = 1'b1;
        cycles(4);
        bus.PAR_EN     = 1'b0;
        cycles(10);

        // Data_Valid held high: next accept lands 12 cycles after the first
        bus.P_DATA     = 8'h0F;
        bus.PAR_EN     = 1'b1;
        bus.PAR_Bit    = 1'b0;
        bus.Data_Valid = 1'b1;
        cycles(1);
        push_frame(8'h0F, 1'b1, 1'b0);
        bus.P_DATA = 8'hF0;
        cycles(12);
        push_frame(8'hF0, 1'b1, 1'b0);
        bus.Data_Valid = 1'b0;
        cycles(14);
        check_eq("queue drained after back-to-back", exp_q.size(), 32'd0);

        // Asynchronous reset while data bit 4 is on the line
        send(8'hC3, 1'b1, 1'b0);
        cycles(4);
        #1;
        RST = 1'b1;
        exp_q.delete();
        #1;
        check_eq("mid-frame reset TX_OUT", {31'd0, bus.TX_OUT}, 32'd1);
        check_eq("mid-frame reset Busy",   {31'd0, bus.Busy},   32'd0);
        cycles(3);
        RST = 1'b0;
        send(8'h81, 1'b1, 1'b0);
        cycles(14);
        check_eq("queue drained at end", exp_q.size(), 32'd0);

        mon_en = 1'b0;
        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule

// File: doc/uart_tx_ctrl.md
# uart_tx_ctrl

Frame controller and serializer for the UART transmitter. It sits directly downstream of the parity calculator and drives the serial line. It accepts a parallel word on a valid pulse while idle, then emits start bit, data bits LSB first, an optional parity bit taken from the parity stage, and a stop bit, one bit per `CLK` cycle. It produces the `Busy` flag that the parity stage uses to gate its own data capture.

## Interface
- `DATA_WIDTH`, default 8: number of data bits per frame (≥ 2).

- `CLK`  in  1  bit-rate clock; one serial bit per cycle
- `RST`  in  1  asynchronous reset, active-high
- `P_DATA`  in  DATA_WIDTH  parallel word; sampled only on accept
- `Data_Valid`  in  1  word-valid strobe; honoured only when `Busy`=0
- `PAR_EN`  in  1  parity enable; sampled only on accept
- `PAR_Bit`  in  1  parity bit from the parity stage; sampled when entering PARITY
- `TX_OUT`  out  1  serial line, registered; idle level 1
- `Busy`  out  1  frame in progress, registered

## Operation
- Reset (async, `RST`=1): state=IDLE, `TX_OUT`=1, `Busy`=0, shift register=0, bit counter=0, latched parity enable=0. Takes effect immediately, including mid-frame. The partial frame is abandoned and not resumed.
- FSM states: IDLE, START, DATA, PARITY, STOP.
  - IDLE: `TX_OUT`=1, `Busy`=0. If `Data_Valid`=1 at an edge, that edge is the **accept**:
    - load `P_DATA` into the shift register
    - latch `PAR_EN`
    - clear the bit counter
    - go to START
  - START: `TX_OUT`=0. Next state is DATA.
  - DATA: `TX_OUT`=shift[0]. Shift right once per cycle and count. After bit DATA_WIDTH-1, go to PARITY if the latched enable is 1, else go to STOP.
  - PARITY: `TX_OUT`=`PAR_Bit`, sampled at the edge entering the state. Next state is STOP.
  - STOP: `TX_OUT`=1. Next state is IDLE.
- `Busy`=1 in every state except IDLE.
- `Data_Valid` is ignored while `Busy`=1; no queuing.
- `P_DATA` and `PAR_EN` changes after accept have no effect on the current frame.
- Bit counter width is clog2(DATA_WIDTH). It never wraps within a frame and is cleared on accept.
- Contract with the parity stage: that stage captures on the same `Data_Valid && !Busy` condition and updates `PAR_Bit` within 2 edges of accept. `PAR_Bit` must then stay stable until the frame ends. This block does not compute parity.

## Timing
- Accept edge E0 (`Data_Valid`=1, `Busy`=0 sampled). After E0: `TX_OUT`=0 (start bit), `Busy`=1.
- After E1 … E(DATA_WIDTH): `TX_OUT`=D[0] … D[DATA_WIDTH-1].
- Parity enabled:
  - after E(DATA_WIDTH+1): `TX_OUT`=`PAR_Bit`
  - after E(DATA_WIDTH+2): `TX_OUT`=1 (stop)
  - after E(DATA_WIDTH+3): IDLE, `Busy`=0
  - `Busy` is high for DATA_WIDTH+3 cycles (11 at default)
- Parity disabled: stop bit after E(DATA_WIDTH+1), IDLE after E(DATA_WIDTH+2). `Busy` is high for DATA_WIDTH+2 cycles (10 at default).
- Latency from accept to start bit on the line: 1 edge (registered output).
- Back-to-back: `Busy` drops at the edge that leaves STOP. The earliest next accept is the following edge, so there is exactly 1 idle cycle (`TX_OUT`=1) between frames.
- `Data_Valid` held high continuously: a new frame is accepted every DATA_WIDTH+4 cycles (parity on) or every DATA_WIDTH+3 cycles (parity off).
- `RST` asserted at any cycle: `TX_OUT`=1 and `Busy`=0 immediately (no clock needed). After release, the first accept is possible at the first edge.

## Test plan
- Reset: assert `RST` with no clock → `TX_OUT`=1, `Busy`=0. Release and hold `Data_Valid`=0 for 20 cycles → line stays 1, `Busy` stays 0.
- Parity frame: `P_DATA`=0xA5, `PAR_EN`=1, `PAR_Bit`=0, one-cycle `Data_Valid` → `TX_OUT` after E0…E10 = 0,1,0,1,0,0,1,0,1,0,1. `Busy` is high for 11 cycles.
- No-parity frame: `P_DATA`=0x3C, `PAR_EN`=0 → `TX_OUT` = 0,0,0,1,1,1,1,0,0,1. `Busy` is high for 10 cycles. `PAR_Bit` toggling has no effect.
- Busy ignore: accept 0x55, then pulse `Data_Valid` with `P_DATA`=0xFF and toggle `PAR_EN` mid-frame → frame for 0x55 is unchanged and no second frame follows.
- Back-to-back: `Data_Valid` held high with 0x0F then 0xF0 (parity on) → second start bit appears exactly 12 cycles after the first, with one idle-1 cycle between the frames.
- Reset mid-frame: assert `RST` during DATA bit 4 → `TX_OUT`=1 and `Busy`=0 asynchronously. After release, a new accept of 0x81 produces a clean full frame.
